// File: rtl/reg_file_pkg.sv
// Shared constants for the MIPS register file and its HI/LO sub-block.
package reg_file_pkg;

  localparam int DATA_WIDTH     = 32;
  localparam int REG_ADDR_WIDTH = 5;
  localparam int REG_NUM        = 32;

  localparam logic [DATA_WIDTH-1:0]     ZERO_WORD     = 32'h0000_0000;
  localparam logic [REG_ADDR_WIDTH-1:0] REG_ZERO_ADDR = 5'd0;

endpackage : reg_file_pkg

// File: rtl/reg_file_hilo_reg.sv
// HI/LO register pair: async active-low clear, joint update, write-through forwarding.
module reg_file_hilo_reg #(
  parameter int DATA_WIDTH = reg_file_pkg::DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  hilo_write_enabler,
  input  logic [DATA_WIDTH-1:0] hi_input,
  input  logic [DATA_WIDTH-1:0] lo_input,
  output logic [DATA_WIDTH-1:0] hi_output,
  output logic [DATA_WIDTH-1:0] lo_output
);
  import reg_file_pkg::*;

  logic [DATA_WIDTH-1:0] hi_q, hi_d;
  logic [DATA_WIDTH-1:0] lo_q, lo_d;

  // Next HI/LO: both halves load together on a strobe, otherwise hold.
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (hilo_write_enabler) begin
      hi_d = hi_input;
      lo_d = lo_input;
    end else begin
      hi_d = hi_q;
      lo_d = lo_q;
    end
  end

  // HI/LO storage, cleared immediately when rst drops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi_q <= DATA_WIDTH'(ZERO_WORD);
      lo_q <= DATA_WIDTH'(ZERO_WORD);
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  // Output mux: zero in reset, forward incoming values during a write, else stored pair.
  always_comb begin
    hi_output = DATA_WIDTH'(ZERO_WORD);
    lo_output = DATA_WIDTH'(ZERO_WORD);
    if (!rst) begin
      hi_output = DATA_WIDTH'(ZERO_WORD);
      lo_output = DATA_WIDTH'(ZERO_WORD);
    end else if (hilo_write_enabler) begin
      hi_output = hi_input;
      lo_output = lo_input;
    end else begin
      hi_output = hi_q;
      lo_output = lo_q;
    end
  end

endmodule : reg_file_hilo_reg

// File: rtl/reg_file.sv
// MIPS GPR file ($0 hardwired to zero) with two combinational forwarding read
// ports, one clocked write port, and the HI/LO pair.
module reg_file #(
  parameter int DATA_WIDTH = reg_file_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = reg_file_pkg::REG_ADDR_WIDTH,
  parameter int REG_NUM    = reg_file_pkg::REG_NUM
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  reg1_read_enabler,
  input  logic [ADDR_WIDTH-1:0] reg1_addr,
  output logic [DATA_WIDTH-1:0] reg1_data,
  input  logic                  reg2_read_enabler,
  input  logic [ADDR_WIDTH-1:0] reg2_addr,
  output logic [DATA_WIDTH-1:0] reg2_data,
  input  logic                  write_enabler,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  hilo_write_enabler,
  input  logic [DATA_WIDTH-1:0] hi_input,
  input  logic [DATA_WIDTH-1:0] lo_input,
  output logic [DATA_WIDTH-1:0] hi_output,
  output logic [DATA_WIDTH-1:0] lo_output
);
  import reg_file_pkg::*;

  localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(REG_ZERO_ADDR);
  localparam logic [DATA_WIDTH-1:0] ZERO_DATA = DATA_WIDTH'(ZERO_WORD);

  logic [DATA_WIDTH-1:0] gpr_q [REG_NUM];
  logic [DATA_WIDTH-1:0] gpr_d [REG_NUM];
  logic                  gpr_write_s;

  // A write only counts when it targets a real register; $0 writes vanish here.
  assign gpr_write_s = write_enabler && (write_addr != ZERO_ADDR);

  // Next array contents: hold everything, overwrite the addressed entry, pin $0.
  always_comb begin
    gpr_d = gpr_q;
    if (gpr_write_s) begin
      gpr_d[write_addr] = write_data;
    end else begin
      gpr_d = gpr_q;
    end
    gpr_d[0] = ZERO_DATA;
  end

  // GPR storage; the whole array clears the moment rst drops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < REG_NUM; i++) begin
        gpr_q[i] <= ZERO_DATA;
      end
    end else begin
      gpr_q <= gpr_d;
    end
  end

  // Read port 1: reset, $0 and disabled reads give zero; same-cycle write is forwarded.
  always_comb begin
    reg1_data = ZERO_DATA;
    if (!rst) begin
      reg1_data = ZERO_DATA;
    end else if (reg1_addr == ZERO_ADDR) begin
      reg1_data = ZERO_DATA;
    end else if (!reg1_read_enabler) begin
      reg1_data = ZERO_DATA;
    end else if (write_enabler && (write_addr == reg1_addr)) begin
      reg1_data = write_data;
    end else begin
      reg1_data = gpr_q[reg1_addr];
    end
  end

  // Read port 2: identical priority to port 1, independent address and enable.
  always_comb begin
    reg2_data = ZERO_DATA;
    if (!rst) begin
      reg2_data = ZERO_DATA;
    end else if (reg2_addr == ZERO_ADDR) begin
      reg2_data = ZERO_DATA;
    end else if (!reg2_read_enabler) begin
      reg2_data = ZERO_DATA;
    end else if (write_enabler && (write_addr == reg2_addr)) begin
      reg2_data = write_data;
    end else begin
      reg2_data = gpr_q[reg2_addr];
    end
  end

  reg_file_hilo_reg #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_hilo_reg (
    .clk               (clk),
    .rst               (rst),
    .hilo_write_enabler(hilo_write_enabler),
    .hi_input          (hi_input),
    .lo_input          (lo_input),
    .hi_output         (hi_output),
    .lo_output         (lo_output)
  );

endmodule : reg_file

// File: tb/tb_reg_file.sv
// Directed self-checking bench for reg_file.
module tb_reg_file;

  logic        clk;
  logic        rst;
  logic        reg1_read_enabler;
  logic [4:0]  reg1_addr;
  logic [31:0] reg1_data;
  logic        reg2_read_enabler;
  logic [4:0]  reg2_addr;
  logic [31:0] reg2_data;
  logic        write_enabler;
  logic [4:0]  write_addr;
  logic [31:0] write_data;
  logic        hilo_write_enabler;
  logic [31:0] hi_input;
  logic [31:0] lo_input;
  logic [31:0] hi_output;
  logic [31:0] lo_output;

  int tests_run;
  int tests_failed;

  reg_file dut (
    .clk               (clk),
    .rst               (rst),
    .reg1_read_enabler (reg1_read_enabler),
    .reg1_addr         (reg1_addr),
    .reg1_data         (reg1_data),
    .reg2_read_enabler (reg2_read_enabler),
    .reg2_addr         (reg2_addr),
    .reg2_data         (reg2_data),
    .write_enabler     (write_enabler),
    .write_addr        (write_addr),
    .write_data        (write_data),
    .hilo_write_enabler(hilo_write_enabler),
    .hi_input          (hi_input),
    .lo_input          (lo_input),
    .hi_output         (hi_output),
    .lo_output         (lo_output)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change on the falling edge; outputs are sampled 1 time unit later.
  task automatic idle();
    reg1_read_enabler  = 1'b0;
    reg1_addr          = 5'd0;
    reg2_read_enabler  = 1'b0;
    reg2_addr          = 5'd0;
    write_enabler      = 1'b0;
    write_addr         = 5'd0;
    write_data         = 32'h0;
    hilo_write_enabler = 1'b0;
    hi_input           = 32'h0;
    lo_input           = 32'h0;
  endtask

  task automatic do_write(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    idle();
    write_enabler = 1'b1;
    write_addr    = a;
    write_data    = d;
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic set_reads(input logic [4:0] a1, input logic [4:0] a2);
    reg1_read_enabler = 1'b1;
    reg1_addr         = a1;
    reg2_read_enabler = 1'b1;
    reg2_addr         = a2;
  endtask

  task automatic test_reset();
    // Outputs are zero while held in reset at time zero.
    #1;
    tests_run++;
    if (reg1_data !== 32'h0 || reg2_data !== 32'h0 || hi_output !== 32'h0 || lo_output !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_initial: r1=%h r2=%h hi=%h lo=%h required all 0", reg1_data, reg2_data, hi_output, lo_output);
    end
    // A write presented during reset must not land.
    @(negedge clk);
    write_enabler = 1'b1;
    write_addr    = 5'd10;
    write_data    = 32'hCAFE_F00D;
    @(negedge clk);
    idle();
    rst = 1'b1;
    set_reads(5'd10, 5'd10);
    #1;
    tests_run++;
    if (reg1_data !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_write_ignored: r1=%h required 00000000", reg1_data);
    end
    idle();
    do_write(5'd5, 32'hDEAD_BEEF);
    @(negedge clk);
    set_reads(5'd5, 5'd5);
    #1;
    tests_run++;
    if (reg1_data !== 32'hDEAD_BEEF || reg2_data !== 32'hDEAD_BEEF) begin
      tests_failed++;
      $display("FAIL reset_pre_write: r1=%h r2=%h required deadbeef", reg1_data, reg2_data);
    end
    // Asynchronous assertion mid-cycle clears immediately.
    rst = 1'b0;
    #1;
    tests_run++;
    if (reg1_data !== 32'h0 || reg2_data !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_during: r1=%h r2=%h required 0", reg1_data, reg2_data);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    tests_run++;
    if (reg1_data !== 32'h0 || reg2_data !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_after_release: r1=%h r2=%h required 0", reg1_data, reg2_data);
    end
    idle();
  endtask

  task automatic test_basic();
    do_write(5'd3, 32'h1234_5678);
    @(negedge clk);
    reg1_read_enabler = 1'b1;
    reg1_addr         = 5'd3;
    #1;
    tests_run++;
    if (reg1_data !== 32'h1234_5678) begin
      tests_failed++;
      $display("FAIL basic_read: r1=%h required 12345678", reg1_data);
    end
    reg1_read_enabler = 1'b0;
    #1;
    tests_run++;
    if (reg1_data !== 32'h0) begin
      tests_failed++;
      $display("FAIL basic_read_disabled: r1=%h required 00000000", reg1_data);
    end
    idle();
  endtask

  task automatic test_zero_reg();
    do_write(5'd0, 32'hFFFF_FFFF);
    @(negedge clk);
    set_reads(5'd0, 5'd0);
    #1;
    tests_run++;
    if (reg1_data !== 32'h0 || reg2_data !== 32'h0) begin
      tests_failed++;
      $display("FAIL zero_stored: r1=%h r2=%h required 0", reg1_data, reg2_data);
    end
    write_enabler = 1'b1;
    write_addr    = 5'd0;
    write_data    = 32'hFFFF_FFFF;
    #1;
    tests_run++;
    if (reg1_data !== 32'h0 || reg2_data !== 32'h0) begin
      tests_failed++;
      $display("FAIL zero_forward: r1=%h r2=%h required 0", reg1_data, reg2_data);
    end
    idle();
  endtask

  task automatic test_forward();
    @(negedge clk);
    set_reads(5'd7, 5'd7);
    write_enabler = 1'b1;
    write_addr    = 5'd7;
    write_data    = 32'hA5A5_A5A5;
    #1;
    tests_run++;
    if (reg1_data !== 32'hA5A5_A5A5 || reg2_data !== 32'hA5A5_A5A5) begin
      tests_failed++;
      $display("FAIL forward_same_cycle: r1=%h r2=%h required a5a5a5a5", reg1_data, reg2_data);
    end
    @(negedge clk);
    write_enabler = 1'b0;
    write_data    = 32'h0;
    #1;
    tests_run++;
    if (reg1_data !== 32'hA5A5_A5A5 || reg2_data !== 32'hA5A5_A5A5) begin
      tests_failed++;
      $display("FAIL forward_stored: r1=%h r2=%h required a5a5a5a5", reg1_data, reg2_data);
    end
    idle();
  endtask

  task automatic test_port_independence();
    do_write(5'd1, 32'h0000_0001);
    do_write(5'd2, 32'h0000_0002);
    @(negedge clk);
    set_reads(5'd2, 5'd1);
    write_enabler = 1'b1;
    write_addr    = 5'd1;
    write_data    = 32'h0000_0099;
    #1;
    tests_run++;
    if (reg1_data !== 32'h0000_0002 || reg2_data !== 32'h0000_0099) begin
      tests_failed++;
      $display("FAIL port_independence: r1=%h r2=%h required 00000002/00000099", reg1_data, reg2_data);
    end
    @(negedge clk);
    write_enabler = 1'b0;
    #1;
    tests_run++;
    if (reg1_data !== 32'h0000_0002 || reg2_data !== 32'h0000_0099) begin
      tests_failed++;
      $display("FAIL port_independence_stored: r1=%h r2=%h required 00000002/00000099", reg1_data, reg2_data);
    end
    idle();
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    write_enabler = 1'b1;
    write_addr    = 5'd8;
    write_data    = 32'h8888_0008;
    @(negedge clk);
    write_addr    = 5'd9;
    write_data    = 32'h9999_0009;
    @(negedge clk);
    idle();
    set_reads(5'd8, 5'd9);
    #1;
    tests_run++;
    if (reg1_data !== 32'h8888_0008 || reg2_data !== 32'h9999_0009) begin
      tests_failed++;
      $display("FAIL back_to_back: r1=%h r2=%h required 88880008/99990009", reg1_data, reg2_data);
    end
    // Earlier register untouched by the later writes.
    reg1_addr = 5'd3;
    #1;
    tests_run++;
    if (reg1_data !== 32'h1234_5678) begin
      tests_failed++;
      $display("FAIL back_to_back_other: r1=%h required 12345678", reg1_data);
    end
    idle();
  endtask

  task automatic test_hilo();
    @(negedge clk);
    hilo_write_enabler = 1'b1;
    hi_input           = 32'h0000_0011;
    lo_input           = 32'h0000_0022;
    #1;
    tests_run++;
    if (hi_output !== 32'h0000_0011 || lo_output !== 32'h0000_0022) begin
      tests_failed++;
      $display("FAIL hilo_forward: hi=%h lo=%h required 00000011/00000022", hi_output, lo_output);
    end
    @(negedge clk);
    hilo_write_enabler = 1'b0;
    hi_input           = 32'h0000_0077;
    lo_input           = 32'h0000_0088;
    #1;
    tests_run++;
    if (hi_output !== 32'h0000_0011 || lo_output !== 32'h0000_0022) begin
      tests_failed++;
      $display("FAIL hilo_held: hi=%h lo=%h required 00000011/00000022", hi_output, lo_output);
    end
    rst = 1'b0;
    #1;
    tests_run++;
    if (hi_output !== 32'h0 || lo_output !== 32'h0) begin
      tests_failed++;
      $display("FAIL hilo_reset: hi=%h lo=%h required 0", hi_output, lo_output);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    tests_run++;
    if (hi_output !== 32'h0 || lo_output !== 32'h0) begin
      tests_failed++;
      $display("FAIL hilo_after_reset: hi=%h lo=%h required 0", hi_output, lo_output);
    end
    idle();
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst          = 1'b0;
    idle();
    test_reset();
    test_basic();
    test_zero_reg();
    test_forward();
    test_port_independence();
    test_back_to_back();
    test_hilo();
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_reg_file
